// File: rtl/apb4_wdt.sv
// APB4 watchdog timer: a first expiry raises a warning interrupt, and a second expiry without a
// feed drives a fixed-length active-low reset pulse to the reset/clock control unit.
module apb4_wdt #(
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned PSCR_WIDTH = 16,
  parameter int unsigned RST_CYC    = 16,
  parameter logic [31:0] FEED_KEY   = 32'h5A5A_A5A5
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        irq_o,
  output logic        wdt_rst_n_o
);

  localparam int unsigned RcW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RcW-1:0] RcLast = RcW'(RST_CYC - 1);

  typedef enum logic [1:0] {StIdle, StRun, StWarn, StRst} state_e;

  state_e                r_state, w_state_d;
  logic                  r_en, r_irq_en, r_rst_en, r_tof, r_wdt_rst_n;
  logic [PSCR_WIDTH-1:0] r_pscr, r_pscr_cnt, w_pscr_cnt_d;
  logic [CNT_WIDTH-1:0]  r_cmp, r_cnt, w_cnt_d;
  logic [RcW-1:0]        r_rst_cnt, w_rst_cnt_d;

  logic       w_wr, w_rd;
  logic [3:0] w_addr;
  logic       w_ctrl_wr, w_pscr_wr, w_cmp_wr, w_stat_wr, w_feed, w_en_off;
  logic       w_active, w_tick, w_timeout, w_tof_set, w_en_clr;
  logic       w_unused;

  assign w_addr    = paddr[5:2];
  assign w_wr      = psel & penable & pwrite;
  assign w_rd      = psel & penable & ~pwrite;
  assign w_ctrl_wr = w_wr && (w_addr == 4'd0);
  assign w_pscr_wr = w_wr && (w_addr == 4'd1);
  assign w_cmp_wr  = w_wr && (w_addr == 4'd2);
  assign w_stat_wr = w_wr && (w_addr == 4'd5);
  assign w_feed    = w_wr && (w_addr == 4'd4) && (pwdata == FEED_KEY);
  assign w_en_off  = w_ctrl_wr && !pwdata[0];
  assign w_unused  = ^{paddr[31:6], paddr[1:0]};

  assign w_active  = (r_state == StRun) || (r_state == StWarn);
  assign w_tick    = w_active && (r_pscr_cnt == r_pscr);
  assign w_timeout = w_tick && (r_cnt == r_cmp);
  // A feed landing on the timeout cycle wins outright.
  assign w_tof_set = w_timeout && !w_feed;

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_pscr_cnt_d = r_pscr_cnt;
    w_rst_cnt_d  = r_rst_cnt;
    w_en_clr     = 1'b0;
    case (r_state)
      StIdle: begin
        w_cnt_d      = '0;
        w_pscr_cnt_d = '0;
        w_rst_cnt_d  = '0;
        if (r_en && !w_en_off) w_state_d = StRun;
      end
      StRun, StWarn: begin
        if (w_tick) begin
          w_pscr_cnt_d = '0;
          w_cnt_d      = w_timeout ? '0 : r_cnt + CNT_WIDTH'(1);
        end else begin
          w_pscr_cnt_d = r_pscr_cnt + PSCR_WIDTH'(1);
        end
        if (w_en_off) begin
          w_state_d    = StIdle;
          w_cnt_d      = '0;
          w_pscr_cnt_d = '0;
        end else if (w_feed) begin
          w_state_d    = StRun;
          w_cnt_d      = '0;
          w_pscr_cnt_d = '0;
        end else if (w_timeout) begin
          if (r_state == StRun) begin
            w_state_d = StWarn;
          end else if (r_rst_en) begin
            w_state_d   = StRst;
            w_rst_cnt_d = '0;
          end
        end
      end
      StRst: begin
        // Pulse length is fixed: EN writes and feeds cannot cut it short.
        w_rst_cnt_d = r_rst_cnt + RcW'(1);
        if (r_rst_cnt == RcLast) begin
          w_state_d    = StIdle;
          w_cnt_d      = '0;
          w_pscr_cnt_d = '0;
          w_rst_cnt_d  = '0;
          w_en_clr     = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_pscr_cnt  <= '0;
      r_rst_cnt   <= '0;
      r_wdt_rst_n <= 1'b1;
      r_en        <= 1'b0;
      r_irq_en    <= 1'b0;
      r_rst_en    <= 1'b0;
      r_pscr      <= '0;
      r_cmp       <= '0;
      r_tof       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_pscr_cnt  <= w_pscr_cnt_d;
      r_rst_cnt   <= w_rst_cnt_d;
      r_wdt_rst_n <= (w_state_d != StRst);
      if (w_ctrl_wr) {r_rst_en, r_irq_en, r_en} <= pwdata[2:0];
      if (w_en_clr) r_en <= 1'b0;
      if (w_pscr_wr) r_pscr <= pwdata[PSCR_WIDTH-1:0];
      if (w_cmp_wr) r_cmp <= pwdata[CNT_WIDTH-1:0];
      if (w_tof_set) begin
        r_tof <= 1'b1;
      end else if (w_stat_wr && pwdata[0]) begin
        r_tof <= 1'b0;
      end
    end
  end

  always_comb begin
    prdata = '0;
    if (w_rd) begin
      case (w_addr)
        4'd0:    prdata = {29'd0, r_rst_en, r_irq_en, r_en};
        4'd1:    prdata = 32'(r_pscr);
        4'd2:    prdata = 32'(r_cmp);
        4'd3:    prdata = 32'(r_cnt);
        4'd5:    prdata = {31'd0, r_tof};
        default: prdata = '0;
      endcase
    end
  end

  assign pready      = 1'b1;
  assign pslverr     = 1'b0;
  assign irq_o       = r_tof & r_irq_en;
  assign wdt_rst_n_o = r_wdt_rst_n;

endmodule

// File: tb/tb_apb4_wdt.sv
// Directed bench for apb4_wdt: register-map vector table plus timed sequences for the
// two-stage timeout, feeding, W1C, EN-during-reset and asynchronous reset corner cases.
module tb_apb4_wdt;

  localparam logic [31:0] Key      = 32'h5A5A_A5A5;
  localparam logic [31:0] AdrCtrl  = 32'h00;
  localparam logic [31:0] AdrPscr  = 32'h04;
  localparam logic [31:0] AdrCmp   = 32'h08;
  localparam logic [31:0] AdrCnt   = 32'h0C;
  localparam logic [31:0] AdrFeed  = 32'h10;
  localparam logic [31:0] AdrStat  = 32'h14;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr, irq_o, wdt_rst_n_o;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  bit rst_low_seen = 1'b0;
  bit irq_seen = 1'b0;
  bit bus_bad = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  apb4_wdt dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .paddr       (paddr),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .irq_o       (irq_o),
    .wdt_rst_n_o (wdt_rst_n_o)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;
  always @(negedge pclk) if (pslverr !== 1'b0 || pready !== 1'b1) bus_bad = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Both bus tasks start 1 unit after an edge; the access edge is the second edge after the call.
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge pclk); #1 penable = 1'b1;
    #1 d = prdata;
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic step();
    @(posedge pclk); #1;
    if (!wdt_rst_n_o) rst_low_seen = 1'b1;
    if (irq_o) irq_seen = 1'b1;
  endtask

  task automatic run_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic wait_irq(input logic val, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      step();
      if (irq_o === val) at = cyc;
    end
  endtask

  task automatic wait_wdt(input logic val, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      step();
      if (wdt_rst_n_o === val) at = cyc;
    end
  endtask

  task automatic do_reset();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    presetn = 1'b0;
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;
  endtask

  task automatic setup(input logic [31:0] ctrl, output int w);
    apb_write(AdrPscr, 32'd3);
    apb_write(AdrCmp, 32'd9);
    apb_write(AdrCtrl, ctrl);
    w = cyc;
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] d;
    for (int a = 0; a < 6; a++) begin
      apb_read(32'(a * 4), d);
      check($sformatf("%s_reg%0d_zero", tag, a), d, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[10];
    logic [31:0] d;
    int          w, at, at2, n;
    bit          done;

    vecs[0] = '{"ctrl_rw",      AdrCtrl,  32'hFFFF_FFFE, 32'h0000_0006};
    vecs[1] = '{"pscr_rw",      AdrPscr,  32'hDEAD_BEEF, 32'h0000_BEEF};
    vecs[2] = '{"cmp_rw",       AdrCmp,   32'h1234_5678, 32'h1234_5678};
    vecs[3] = '{"cnt_ro",       AdrCnt,   32'hFFFF_FFFF, 32'h0000_0000};
    vecs[4] = '{"feed_wo",      AdrFeed,  Key,           32'h0000_0000};
    vecs[5] = '{"stat_w1c",     AdrStat,  32'h0000_0001, 32'h0000_0000};
    vecs[6] = '{"unmapped_18",  32'h18,   32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{"unmapped_3c",  32'h3C,   32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8] = '{"cmp_cleared",  AdrCmp,   32'h0000_0000, 32'h0000_0000};
    vecs[9] = '{"ctrl_cleared", AdrCtrl,  32'h0000_0000, 32'h0000_0000};

    // Reset values and register map
    do_reset();
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_wdt", 32'(wdt_rst_n_o), 32'd1);
    check_all_zero("rst");
    for (int i = 0; i < 10; i++) begin
      apb_write(vecs[i].addr, vecs[i].wdata);
      apb_read(vecs[i].addr, d);
      check(vecs[i].name, d, vecs[i].exp);
    end
    apb_read(AdrPscr, d);
    check("pscr_no_alias", d, 32'h0000_BEEF);

    // Two-stage timeout with reset pulse
    do_reset();
    setup(32'd7, w);
    wait_irq(1'b1, 60, at);
    check("t1_irq_rise", 32'(at - w), 32'd41);
    apb_read(AdrCnt, d);
    check("t1_cnt_after_to", d, 32'd0);
    apb_read(AdrStat, d);
    check("t1_stat_tof", d, 32'd1);
    wait_wdt(1'b0, 60, at);
    check("t1_rst_fall", 32'(at - w), 32'd81);
    n = 1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (wdt_rst_n_o === 1'b0) n++;
      else done = 1'b1;
    end
    check("t1_rst_len", 32'(n), 32'd16);
    apb_read(AdrCtrl, d);
    check("t1_ctrl_after", d, 32'd6);
    apb_read(AdrCnt, d);
    check("t1_cnt_after_rst", d, 32'd0);

    // Periodic feeding keeps everything quiet; a wrong key does nothing
    do_reset();
    setup(32'd7, w);
    rst_low_seen = 1'b0;
    irq_seen = 1'b0;
    for (int k = 0; k < 33; k++) begin
      repeat (28) step();
      apb_write(AdrFeed, Key);
    end
    check("t2_no_irq", 32'(irq_seen), 32'd0);
    check("t2_no_rst", 32'(rst_low_seen), 32'd0);
    repeat (20) step();
    apb_write(AdrFeed, 32'h1234);
    apb_read(AdrCnt, d);
    check("t2_bad_key_cnt", d, 32'd5);

    // RST_EN=0: interrupt only, W1C and re-rise
    do_reset();
    setup(32'd3, w);
    rst_low_seen = 1'b0;
    run_until(w + 45);
    check("t3_irq_first", 32'(irq_o), 32'd1);
    run_until(w + 90);
    check("t3_irq_second", 32'(irq_o), 32'd1);
    apb_write(AdrStat, 32'd1);
    check("t3_irq_w1c", 32'(irq_o), 32'd0);
    wait_irq(1'b1, 60, at);
    check("t3_irq_rerise", 32'(at - w), 32'd121);
    check("t3_no_rst", 32'(rst_low_seen), 32'd0);

    // Feed on the exact second-timeout cycle, then EN=0 during the pulse
    do_reset();
    setup(32'd7, w);
    rst_low_seen = 1'b0;
    run_until(w + 79);
    apb_write(AdrFeed, Key);
    check("t4_feed_cycle", 32'(cyc - w), 32'd81);
    apb_read(AdrCnt, d);
    check("t4_cnt_cleared", d, 32'd0);
    run_until(w + 130);
    check("t4_no_rst", 32'(rst_low_seen), 32'd0);
    wait_wdt(1'b0, 60, at);
    check("t4_rst_fall", 32'(at - w), 32'd161);
    apb_write(AdrCtrl, 32'd0);
    wait_wdt(1'b1, 40, at2);
    check("t4_rst_len_en0", 32'(at2 - at), 32'd16);
    apb_read(AdrCtrl, d);
    check("t4_ctrl_after", d, 32'd0);

    // Asynchronous reset in the middle of a pulse
    do_reset();
    setup(32'd7, w);
    wait_wdt(1'b0, 100, at);
    repeat (5) step();
    check("t5_pre_wdt", 32'(wdt_rst_n_o), 32'd0);
    check("t5_pre_irq", 32'(irq_o), 32'd1);
    #2 presetn = 1'b0;
    #1;
    check("t5_async_wdt", 32'(wdt_rst_n_o), 32'd1);
    check("t5_async_irq", 32'(irq_o), 32'd0);
    @(posedge pclk);
    #1 presetn = 1'b1;
    check_all_zero("t5");
    apb_write(AdrPscr, 32'hFFFF);
    apb_read(32'h3C, d);
    check("t5_unmapped_3c", d, 32'd0);
    check("bus_resp", 32'(bus_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
